// File: rtl/vga_fb_arbiter.sv
// Shares a single-port framebuffer RAM: the display read has priority over two round-robin writers, and front/back swaps happen at vblank start. Optional macro FB_ARB_BLANK_WR_EN limits writes to blanking.
// Latency: the RAM command is registered (+1 cycle), and read data is valid 2 cycles after the grant; writers wait (gnt=0) while the display reads or a swap is pending.
module vga_fb_arbiter #(
  parameter int AW = 17,
  parameter int DW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_hblank,
  input  logic          i_vblank,
  input  logic          i_disp_req,
  input  logic [AW-1:0] i_disp_addr,
  output logic          o_disp_gnt,
  output logic          o_disp_rvalid,
  output logic [DW-1:0] o_disp_rdata,
  input  logic [1:0]    i_wr_req,
  input  logic [AW-1:0] i_wr_addr0,
  input  logic [AW-1:0] i_wr_addr1,
  input  logic [DW-1:0] i_wr_data0,
  input  logic [DW-1:0] i_wr_data1,
  output logic [1:0]    o_wr_gnt,
  input  logic          i_swap_req,
  output logic          o_swap_pending,
  output logic          o_swap_done,
  output logic          o_front_sel,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW:0]   o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_SWAP} state_t;

  state_t        state_q, state_d;
  logic          front_q, front_d;
  logic          vblank_q;
  logic          prio_q, prio_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          rd_p1_q, rvalid_q;
  logic          vb_rise, blank_ok, wr_ok;
  logic [1:0]    wr_gnt;

`ifdef FB_ARB_BLANK_WR_EN
  assign blank_ok = i_hblank | i_vblank;
`else
  logic unused_hblank;
  assign unused_hblank = i_hblank;
  assign blank_ok      = 1'b1;
`endif

  assign vb_rise = i_vblank & ~vblank_q;
  assign wr_ok   = ~i_disp_req & (state_q == S_IDLE) & blank_ok;

  // prio_q names the writer that wins the next contested cycle
  always_comb begin
    wr_gnt = 2'b00;
    prio_d = prio_q;
    if (wr_ok) begin
      case (i_wr_req)
        2'b01:   wr_gnt = 2'b01;
        2'b10:   wr_gnt = 2'b10;
        2'b11:   wr_gnt = prio_q ? 2'b10 : 2'b01;
        default: wr_gnt = 2'b00;
      endcase
    end
    if (wr_gnt[0])      prio_d = 1'b1;
    else if (wr_gnt[1]) prio_d = 1'b0;
  end

  // The buffer bit is captured here, so an access in flight is unaffected by a swap
  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (i_disp_req) begin
      mem_en_d   = 1'b1;
      mem_addr_d = {front_q, i_disp_addr};
    end else if (wr_gnt[0]) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = {~front_q, i_wr_addr0};
      mem_wdata_d = i_wr_data0;
    end else if (wr_gnt[1]) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = {~front_q, i_wr_addr1};
      mem_wdata_d = i_wr_data1;
    end
  end

  always_comb begin
    state_d = state_q;
    front_d = front_q;
    case (state_q)
      S_IDLE:    if (i_swap_req) state_d = S_PENDING;
      S_PENDING: if (vb_rise) begin
        state_d = S_SWAP;
        front_d = ~front_q;
      end
      S_SWAP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      front_q     <= 1'b0;
      vblank_q    <= 1'b0;
      prio_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_p1_q     <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_q     <= front_d;
      vblank_q    <= i_vblank;
      prio_q      <= prio_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_p1_q     <= i_disp_req;
      rvalid_q    <= rd_p1_q;
    end
  end

  assign o_disp_gnt     = i_disp_req;
  assign o_disp_rvalid  = rvalid_q;
  assign o_disp_rdata   = i_mem_rdata;
  assign o_wr_gnt       = wr_gnt;
  assign o_swap_pending = (state_q == S_PENDING);
  assign o_swap_done    = (state_q == S_SWAP);
  assign o_front_sel    = front_q;
  assign o_mem_en       = mem_en_q;
  assign o_mem_we       = mem_we_q;
  assign o_mem_addr     = mem_addr_q;
  assign o_mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: arbitration, read latency, swap sequencing and reset abort.
// Inputs change 1 ns after the rising edge, and outputs are sampled 1 ns after that.
module tb_vga_fb_arbiter;
  localparam int AW = 17;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          hblank, vblank;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_gnt, disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic [1:0]    wr_req, wr_gnt;
  logic [AW-1:0] wr_addr0, wr_addr1;
  logic [DW-1:0] wr_data0, wr_data1;
  logic          swap_req, swap_pending, swap_done, front_sel;
  logic          mem_en, mem_we;
  logic [AW:0]   mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter #(.AW(AW), .DW(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_hblank(hblank), .i_vblank(vblank),
    .i_disp_req(disp_req), .i_disp_addr(disp_addr), .o_disp_gnt(disp_gnt),
    .o_disp_rvalid(disp_rvalid), .o_disp_rdata(disp_rdata),
    .i_wr_req(wr_req), .i_wr_addr0(wr_addr0), .i_wr_addr1(wr_addr1),
    .i_wr_data0(wr_data0), .i_wr_data1(wr_data1), .o_wr_gnt(wr_gnt),
    .i_swap_req(swap_req), .o_swap_pending(swap_pending), .o_swap_done(swap_done),
    .o_front_sel(front_sel), .o_mem_en(mem_en), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; hblank = 1'b1; vblank = 1'b0;
    disp_req = 1'b0; disp_addr = '0; wr_req = 2'b00;
    wr_addr0 = 17'h10; wr_addr1 = 17'h20; wr_data0 = 3'd5; wr_data1 = 3'd2;
    swap_req = 1'b0; mem_rdata = '0;
    #1;
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_rvalid", 32'(disp_rvalid), 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_front", 32'(front_sel), 0);
    chk("rst_pending", 32'(swap_pending), 0);
    chk("rst_addr", 32'(mem_addr), 0);

    // Both writers contending: strict alternation starting at writer 0
    wr_req = 2'b11; #1;
    chk("rr_gnt0", 32'(wr_gnt), 32'h1);
    tick();
    chk("rr_gnt1", 32'(wr_gnt), 32'h2);
    chk("rr_we0", 32'(mem_we), 1);
    chk("rr_addr0", 32'(mem_addr), 32'h20010);
    chk("rr_wdata0", 32'(mem_wdata), 5);
    tick();
    chk("rr_gnt2", 32'(wr_gnt), 32'h1);
    chk("rr_addr1", 32'(mem_addr), 32'h20020);
    chk("rr_wdata1", 32'(mem_wdata), 2);
    tick();
    chk("rr_gnt3", 32'(wr_gnt), 32'h2);
    chk("rr_we2", 32'(mem_we), 1);
    tick();
    wr_req = 2'b00; #1;
    chk("rr_gnt_idle", 32'(wr_gnt), 0);
    chk("rr_we3", 32'(mem_we), 1);
    tick();
    chk("idle_en", 32'(mem_en), 0);
    chk("idle_we", 32'(mem_we), 0);

    // Display read has priority over a requesting writer
    disp_req = 1'b1; disp_addr = 17'h33; wr_req = 2'b01; #1;
    chk("d_gnt0", 32'(disp_gnt), 1);
    chk("d_wgnt0", 32'(wr_gnt), 0);
    tick();
    chk("d_gnt1", 32'(disp_gnt), 1);
    chk("d_wgnt1", 32'(wr_gnt), 0);
    chk("d_en", 32'(mem_en), 1);
    chk("d_we", 32'(mem_we), 0);
    chk("d_addr", 32'(mem_addr), 32'h33);
    chk("d_rv1", 32'(disp_rvalid), 0);
    tick();
    mem_rdata = 3'd3; #1;
    chk("d_wgnt2", 32'(wr_gnt), 0);
    chk("d_rv2", 32'(disp_rvalid), 1);
    chk("d_rdata", 32'(disp_rdata), 3);
    tick();
    disp_req = 1'b0; #1;
    chk("d_wgnt_after", 32'(wr_gnt), 32'h1);
    chk("d_rv3", 32'(disp_rvalid), 1);
    tick();
    wr_req = 2'b00; #1;
    chk("d_rv4", 32'(disp_rvalid), 1);
    chk("d_wr_addr", 32'(mem_addr), 32'h20010);
    chk("d_wr_we", 32'(mem_we), 1);
    tick();
    chk("d_rv5", 32'(disp_rvalid), 0);

    // Swap request outside vblank: writers blocked until the swap executes
    swap_req = 1'b1; tick();
    swap_req = 1'b0; wr_req = 2'b01; #1;
    chk("s_pending", 32'(swap_pending), 1);
    chk("s_wgnt0", 32'(wr_gnt), 0);
    tick();
    vblank = 1'b1; #1;
    chk("s_wgnt1", 32'(wr_gnt), 0);
    chk("s_front0", 32'(front_sel), 0);
    tick();
    chk("s_done", 32'(swap_done), 1);
    chk("s_front1", 32'(front_sel), 1);
    chk("s_pend_clr", 32'(swap_pending), 0);
    chk("s_wgnt2", 32'(wr_gnt), 0);
    tick();
    chk("s_done_clr", 32'(swap_done), 0);
    chk("s_wgnt3", 32'(wr_gnt), 32'h1);
    tick();
    wr_req = 2'b00; vblank = 1'b0; #1;
    chk("s_wr_addr", 32'(mem_addr), 32'h00010);
    chk("s_wr_we", 32'(mem_we), 1);
    tick();

    // Reset one cycle after a display grant: the read is aborted
    disp_req = 1'b1; disp_addr = 17'h44; #1;
    chk("r_gnt", 32'(disp_gnt), 1);
    tick();
    disp_req = 1'b0; #1;
    chk("r_en", 32'(mem_en), 1);
    chk("r_addr", 32'(mem_addr), 32'h20044);
    rst = 1'b1; #1;
    chk("r_en_clr", 32'(mem_en), 0);
    chk("r_front_clr", 32'(front_sel), 0);
    tick();
    rst = 1'b0; #1;
    chk("r_rv0", 32'(disp_rvalid), 0);
    tick();
    chk("r_rv1", 32'(disp_rvalid), 0);
    chk("r_en_idle", 32'(mem_en), 0);
    wr_req = 2'b11; #1;
    chk("r_rr_reset", 32'(wr_gnt), 32'h1);
    tick();
    wr_req = 2'b00; tick();

    // Request on the vblank rise plus a repeat while pending: exactly one toggle at the next rise
    swap_req = 1'b1; vblank = 1'b1; #1;
    chk("v_pend0", 32'(swap_pending), 0);
    tick();
    chk("v_pend1", 32'(swap_pending), 1);
    chk("v_front0", 32'(front_sel), 0);
    tick();
    swap_req = 1'b0; vblank = 1'b0; #1;
    chk("v_pend2", 32'(swap_pending), 1);
    chk("v_front1", 32'(front_sel), 0);
    chk("v_done0", 32'(swap_done), 0);
    tick();
    vblank = 1'b1; #1;
    chk("v_pend3", 32'(swap_pending), 1);
    tick();
    chk("v_done1", 32'(swap_done), 1);
    chk("v_front2", 32'(front_sel), 1);
    tick();
    chk("v_done2", 32'(swap_done), 0);
    chk("v_front3", 32'(front_sel), 1);
    vblank = 1'b0; tick();
    vblank = 1'b1; tick();
    chk("v_no_second", 32'(front_sel), 1);
    chk("v_done3", 32'(swap_done), 0);
    vblank = 1'b0; tick();

    // Writer request outside blanking
    hblank = 1'b0; wr_req = 2'b01; wr_addr0 = 17'h55; #1;
`ifdef FB_ARB_BLANK_WR_EN
    chk("b_noblank", 32'(wr_gnt), 0);
`else
    chk("b_noblank", 32'(wr_gnt), 32'h1);
`endif
    hblank = 1'b1; #1;
    chk("b_hblank", 32'(wr_gnt), 32'h1);
    tick();
    wr_req = 2'b00; #1;
    chk("b_we", 32'(mem_we), 1);
    chk("b_addr", 32'(mem_addr), 32'h00055);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Shares one single-port synchronous framebuffer RAM between the VGA scan-out fetch and two drawing writers. It also manages double-buffer (front/back) selection, with swaps taken only at vertical-blank start. It sits between the hsync/vsync timing generators plus pixel-fetch logic and the framebuffer RAM. All arbitration and swap sequencing is clocked on the pixel clock.

Parameters:
AW, 17, per-buffer address width (word address inside one buffer)
DW, 3, pixel data width ({r,g,b})

Ports:
i_clk  input  1  pixel clock; all logic on rising edge
i_rst  input  1  asynchronous, active-high reset
i_hblank  input  1  horizontal blank from timing generator
i_vblank  input  1  vertical blank from timing generator
i_disp_req  input  1  scan-out read request
i_disp_addr  input  AW  scan-out read address (front buffer)
o_disp_gnt  output  1  combinational grant for the display request this cycle
o_disp_rvalid  output  1  read data valid
o_disp_rdata  output  DW  read data (direct from i_mem_rdata)
i_wr_req  input  2  writer requests, bit n = writer n
i_wr_addr0, i_wr_addr1  input  AW  writer addresses (back buffer)
i_wr_data0, i_wr_data1  input  DW  writer data
o_wr_gnt  output  2  combinational one-hot writer grant
i_swap_req  input  1  single-cycle pulse: back buffer complete, swap at next vblank
o_swap_pending  output  1  swap latched, not yet executed
o_swap_done  output  1  one-cycle pulse when the swap executes
o_front_sel  output  1  current front buffer index
o_mem_en  output  1  registered RAM enable
o_mem_we  output  1  registered RAM write enable
o_mem_addr  output  AW+1  registered RAM address {buffer bit, AW address}
o_mem_wdata  output  DW  registered RAM write data
i_mem_rdata  input  DW  RAM read data, 1-cycle synchronous latency

Behaviour:
- Reset values: all outputs 0; front_sel=0; round-robin pointer selects writer 0 first; swap FSM in IDLE; read-valid pipeline cleared. Reset asserted mid-access aborts it with no late rvalid.
- One RAM access per cycle. Priority: display > writers. o_disp_gnt = i_disp_req, always.
- Writer arbitration runs only when the display is not requesting and writes are permitted.
  - Both writers request: grant the one not granted last; pointer updates only on an actual grant.
  - Single requester: granted directly.
- Writer handshake: the writer holds req/addr/data stable until it sees its gnt bit high at a clock edge. It may deassert req in the cycle after the grant.
- Command register: on a granted cycle N, at edge N+1:
  - o_mem_en=1
  - o_mem_addr = {front_sel, disp_addr} for reads, or {~front_sel, wr_addr} for writes
  - o_mem_we = 1 for writes only
  - o_mem_wdata = granted writer data (holds last value otherwise)
  - With no grant, o_mem_en=0 and o_mem_we=0.
- Read latency: o_disp_rvalid is high exactly 2 cycles after the o_disp_gnt cycle. o_disp_rdata is valid while rvalid=1.
- Swap FSM: IDLE -> PENDING on i_swap_req. PENDING -> SWAP on vblank rising edge (i_vblank=1 and registered previous=0). SWAP -> IDLE after one cycle.
  - In SWAP: front_sel toggles and o_swap_done=1.
  - o_swap_pending=1 in PENDING.
- Writes permitted only in IDLE. Writer grants are 0 in PENDING and SWAP, so the frame queued for display is not modified.
- i_swap_req in PENDING or SWAP is ignored (no double toggle).
- i_swap_req in the same cycle as a vblank rise latches only. That swap occurs at the following vblank rise.
- The buffer bit used in o_mem_addr is sampled at grant time. An access in flight across a swap completes to its original buffer.

Optional Feature:
FB_ARB_BLANK_WR_EN
- Defined: writer grants are additionally gated by (i_hblank | i_vblank), so writes occur only during blanking.
- Undefined: writers may be granted in any cycle the display is idle and the FSM is IDLE.

Test Plan:
- Reset, then i_wr_req=2'b11 with display idle for 4 cycles -> o_wr_gnt sequence 01,10,01,10; o_mem_we=1 each following cycle; o_mem_addr[AW]=1.
- i_disp_req=1 and i_wr_req=2'b01 for 3 cycles -> o_disp_gnt=1 each cycle, o_wr_gnt=00; rvalid high 2 cycles after each grant; o_mem_addr[AW]=0. Writer granted the cycle after disp_req drops.
- i_swap_req pulse with i_vblank=0, writer requesting -> o_swap_pending=1, o_wr_gnt=00. At vblank rise: o_swap_done pulse, o_front_sel=1, writer granted the next cycle with o_mem_addr[AW]=0.
- i_swap_req on the vblank-rise cycle, plus a second i_swap_req while PENDING -> no toggle at this vblank; exactly one toggle at the next vblank rise.
- Assert i_rst one cycle after a display grant -> o_disp_rvalid stays 0, o_front_sel=0, o_mem_en=0 until new requests.
- With FB_ARB_BLANK_WR_EN defined: i_wr_req=01, hblank=vblank=0 -> no grant; raise i_hblank -> o_wr_gnt=01 the same cycle.
